// File: rtl/ws2812_frame_decoder_if.sv
// Byte-write side of the pulse-width serial LED stream decoder, plus the serial line itself.
// The decoder is the master: it samples data_in and drives the byte/frame status outputs.
interface ws2812_frame_decoder_if;
  logic       data_in;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic [7:0] byte_addr;
  logic       frame_done;
  logic       busy;
  logic       bit_error;
  logic       overflow;

  modport master (
    input  data_in,
    output byte_valid,
    output byte_data,
    output byte_addr,
    output frame_done,
    output busy,
    output bit_error,
    output overflow
  );

  modport slave (
    output data_in,
    input  byte_valid,
    input  byte_data,
    input  byte_addr,
    input  frame_done,
    input  busy,
    input  bit_error,
    input  overflow
  );
endinterface

// File: rtl/ws2812_frame_decoder.sv
// Decodes a pulse-width-coded single-wire LED stream into addressed bytes, detecting the
// long-low frame latch, malformed pulses, partial bytes and frame overflow.
module ws2812_frame_decoder #(
  parameter int unsigned N_LEDS     = 25,
  parameter int unsigned T_THRESH   = 60,
  parameter int unsigned T_MAX_HIGH = 120,
  parameter int unsigned T_LATCH    = 5000
) (
  input  logic                          clk,
  input  logic                          reset,
  ws2812_frame_decoder_if.master        bus
);

  localparam int unsigned CntW = $clog2(T_LATCH + 1);

  localparam logic [CntW-1:0] CntMax    = '1;
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] LatchLast = CntW'(T_LATCH - 1);
  localparam logic [CntW-1:0] Thresh    = CntW'(T_THRESH);
  localparam logic [CntW-1:0] MaxHigh   = CntW'(T_MAX_HIGH);
  localparam logic [7:0]      CapAddr   = 8'(3 * N_LEDS);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  logic din_m, din_s, din_d;
  logic rise, fall;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      addr_q, addr_d;
  logic            byte_valid_q, byte_valid_d;
  logic [7:0]      byte_data_q, byte_data_d;
  logic [7:0]      byte_addr_q, byte_addr_d;
  logic            frame_done_q, frame_done_d;
  logic            bit_error_q, bit_error_d;
  logic            overflow_q, overflow_d;
  logic            bit_val;
  logic [7:0]      new_byte;

  // Two-flop synchroniser plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= bus.data_in;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise     = din_s & ~din_d;
  assign fall     = ~din_s & din_d;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
  assign bit_val  = (cnt_q >= Thresh);
  assign new_byte = {shift_q[6:0], bit_val};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    addr_d       = addr_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    byte_addr_d  = byte_addr_q;
    frame_done_d = 1'b0;
    bit_error_d  = 1'b0;
    overflow_d   = overflow_q;

    unique case (state_q)
      StSync: begin
        if (din_s) begin
          cnt_d = '0;
        end else if (cnt_q >= LatchLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StIdle: begin
        if (rise) begin
          cnt_d   = CntOne;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (fall) begin
          shift_d   = new_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          cnt_d     = CntOne;
          state_d   = StLow;
          if (bit_cnt_q == 3'd7) begin
            if (addr_q == CapAddr) begin
              overflow_d = 1'b1;
            end else begin
              byte_valid_d = 1'b1;
              byte_data_d  = new_byte;
              byte_addr_d  = addr_q;
              addr_d       = addr_q + 8'd1;
            end
          end
        end else if (cnt_q >= MaxHigh) begin
          // Pulse would exceed the longest legal high time: drop the frame and resync.
          bit_error_d = 1'b1;
          cnt_d       = '0;
          bit_cnt_d   = '0;
          shift_d     = '0;
          addr_d      = '0;
          state_d     = StSync;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StLow: begin
        // Latch wins over a rising edge arriving in the same cycle.
        if (cnt_q >= LatchLast) begin
          frame_done_d = 1'b1;
          bit_error_d  = (bit_cnt_q != 3'd0);
          overflow_d   = 1'b0;
          addr_d       = '0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          cnt_d        = '0;
          state_d      = StIdle;
        end else if (rise) begin
          cnt_d   = CntOne;
          state_d = StHigh;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StSync;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      byte_addr_q  <= '0;
      frame_done_q <= 1'b0;
      bit_error_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_addr_q  <= byte_addr_d;
      frame_done_q <= frame_done_d;
      bit_error_q  <= bit_error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.byte_valid = byte_valid_q;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_addr  = byte_addr_q;
  assign bus.frame_done = frame_done_q;
  assign bus.bit_error  = bit_error_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = (state_q == StHigh) || (state_q == StLow);

endmodule

// File: tb/tb_ws2812_frame_decoder.sv
// Scoreboard bench for ws2812_frame_decoder: a pulse-level model predicts byte, frame and
// error events, and a monitor compares them as the decoder reports them.
module tb_ws2812_frame_decoder;

  localparam int Cap   = 75;
  localparam int Latch = 5000;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ws2812_frame_decoder_if bus ();

  ws2812_frame_decoder #(
    .N_LEDS    (25),
    .T_THRESH  (60),
    .T_MAX_HIGH(120),
    .T_LATCH   (Latch)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EvByte, EvFrame, EvErr} ev_kind_e;
  typedef struct packed {
    logic [1:0] kind;
    logic       err;
    logic       ovf;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs, expv;
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc      = 0;
  int  fall_cyc = 0;
  int  fd_cyc   = -1;

  // Reference model state: decoding enabled, bits in current byte, byte, address, overflow.
  bit         m_active = 1'b0;
  int         m_bits   = 0;
  int         m_addr   = 0;
  logic [7:0] m_byte   = '0;
  bit         m_ovf    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && (bus.byte_valid || bus.frame_done || bus.bit_error)) begin
      if (bus.frame_done) fd_cyc = cyc;
      obs     = '0;
      obs.ovf = bus.overflow;
      if (bus.byte_valid) begin
        obs.kind = EvByte;
        obs.addr = bus.byte_addr;
        obs.data = bus.byte_data;
      end else if (bus.frame_done) begin
        obs.kind = EvFrame;
        obs.err  = bus.bit_error;
      end else begin
        obs.kind = EvErr;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got 0x%0h expected none", obs);
      end else begin
        expv = exp_q.pop_front();
        check("event", 32'(obs), 32'(expv));
      end
    end
  end

  function automatic void push(input ev_kind_e k, input logic err, input logic [7:0] a,
                               input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.err  = err;
    e.ovf  = m_ovf;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_bits   = 0;
    m_addr   = 0;
    m_byte   = '0;
    m_ovf    = 1'b0;
  endfunction

  task automatic low_period(input int l);
    if (m_active && l >= Latch) begin
      m_ovf = 1'b0;
      push(EvFrame, m_bits != 0, 8'h00, 8'h00);
      m_bits = 0;
      m_addr = 0;
    end else if (!m_active && l >= Latch) begin
      m_active = 1'b1;
    end
    bus.data_in = 1'b0;
    fall_cyc    = cyc;
    repeat (l) @(negedge clk);
  endtask

  task automatic pulse(input int h, input int l);
    if (m_active) begin
      if (h > 120) begin
        push(EvErr, 1'b0, 8'h00, 8'h00);
        m_active = 1'b0;
        m_bits   = 0;
        m_addr   = 0;
      end else begin
        m_byte = {m_byte[6:0], (h >= 60)};
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          if (m_addr < Cap) begin
            push(EvByte, 1'b0, 8'(m_addr), m_byte);
            m_addr++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    bus.data_in = 1'b1;
    repeat (h) @(negedge clk);
    low_period(l);
  endtask

  // style 0: fixed 80/45 and 30/95; 1: random legal widths; 2: short pulses, short gaps
  task automatic send_byte(input logic [7:0] b, input int last_low, input int style);
    for (int i = 7; i >= 0; i--) begin
      int h, l;
      case (style)
        0: begin
          h = b[i] ? 80 : 30;
          l = b[i] ? 45 : 95;
        end
        1: begin
          h = b[i] ? int'($urandom_range(120, 60)) : int'($urandom_range(59, 3));
          l = int'($urandom_range(200, 10));
        end
        default: begin
          h = b[i] ? int'($urandom_range(64, 60)) : int'($urandom_range(8, 3));
          l = int'($urandom_range(4, 2));
        end
      endcase
      if (i == 0) l = last_low;
      pulse(h, l);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {10'd0, bus.byte_valid, bus.byte_data, bus.byte_addr, bus.frame_done,
                 bus.busy, bus.bit_error, bus.overflow}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.data_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b1;

    // Sync period after reset: no events, not busy.
    low_period(Latch + 10);
    check("idle_after_sync_busy", bus.busy, 1'b0);

    // 0xA5 with fixed widths; exact latch length and latency.
    send_byte(8'hA5, Latch, 0);
    repeat (3) @(negedge clk);
    check("frame_done_latency", 32'(fd_cyc - fall_cyc), 32'd5002);
    check("idle_after_frame_busy", bus.busy, 1'b0);

    // Partial byte at latch.
    for (int i = 0; i < 4; i++) pulse((i % 2 == 0) ? 80 : 30, 40);
    pulse(80, 40);
    check("busy_mid_frame", bus.busy, 1'b1);
    low_period(Latch);
    send_byte(8'h5A, 50, 1);
    send_byte(8'($urandom), Latch + 3, 1);

    // Over-long high pulse mid-byte, ignored pulses, resync, then 0x3C and width boundaries.
    for (int i = 0; i < 3; i++) pulse(70, 30);
    pulse(150, 20);
    pulse(80, 30);
    pulse(30, 30);
    low_period(Latch + 200);
    send_byte(8'h3C, 30, 0);
    pulse(59, 20);
    pulse(60, 20);
    pulse(120, 20);
    for (int i = 0; i < 5; i++) pulse(($urandom_range(1, 0) == 1) ? 90 : 20, 25);
    pulse(121, Latch + 200);

    // Random frame.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), (i == 3) ? Latch + 7 : 30, 1);

    // Capacity: 75 bytes, then a 76th raises overflow; latch clears it.
    for (int i = 0; i < Cap + 1; i++) send_byte(8'($urandom), 10, 2);
    check("overflow_set", bus.overflow, m_ovf);
    check("overflow_set_const", bus.overflow, 1'b1);
    low_period(Latch + 5);
    check("overflow_cleared", bus.overflow, 1'b0);

    // Reset mid-frame; decoding needs a fresh sync period.
    for (int i = 0; i < 4; i++) pulse(80, 30);
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("mid_frame_reset_outputs");
    reset = 1'b1;
    send_byte(8'hF0, 30, 2);
    low_period(Latch + 200);
    send_byte(8'($urandom), Latch + 5, 1);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
